rot_sin_cos_pipe: RTL and testbench

Pipelined, stream-handshaked successor to the combinational point rotator: rotates a stream of (x, y) points by a latched sin/cos pair, adds a per-point translation offset and rounds to nearest. It sits between the vector-list fetcher (ship/asteroid vertex lists) and the line drawer. It accepts one point per clock under valid/ready backpressure, and passes a last-vertex marker through with each point.

---
 rtl/rot_sin_cos_pipe_if.sv | 42 ++++
 rtl/rot_sin_cos_pipe.sv | 167 ++++++++++++++++
 tb/tb_rot_sin_cos_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rot_sin_cos_pipe_if.sv
// rtl/rot_sin_cos_pipe_if.sv - point stream, angle load and result stream bundle for rot_sin_cos_pipe
//
// Purpose: groups the angle-load inputs, the input point stream and the
//          output result stream of the rotator.
// Ports (signals):
//   ang_load, sin_in, cos_in        angle capture (sin/cos are Q1.17 in 18 bits)
//   in_valid, in_ready              input point handshake
//   x, y, ox, oy, in_last           input point, translation and last-vertex marker
//   out_valid, out_ready            result handshake
//   rx, ry, out_last                rotated + translated result and its marker
// Modports: master drives points and accepts results (fetcher/drawer side),
//           slave is the rotator.

interface rot_sin_cos_pipe_if #(
    parameter int DATA_W = 18
);
    logic                     ang_load;
    logic signed [17:0]       sin_in;
    logic signed [17:0]       cos_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] ox;
    logic signed [DATA_W-1:0] oy;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] rx;
    logic signed [DATA_W-1:0] ry;
    logic                     out_last;

    modport master (
        output ang_load, sin_in, cos_in, in_valid, x, y, ox, oy, in_last, out_ready,
        input  in_ready, out_valid, rx, ry, out_last
    );

    modport slave (
        input  ang_load, sin_in, cos_in, in_valid, x, y, ox, oy, in_last, out_ready,
        output in_ready, out_valid, rx, ry, out_last
    );
endinterface

// File: rtl/rot_sin_cos_pipe.sv
// rtl/rot_sin_cos_pipe.sv - three-stage point rotator with translation and round-to-nearest
//
// Purpose: rotates a stream of (x, y) points by a latched sin/cos pair, adds a
//          per-point offset and rounds half-up, one point per clock under
//          valid/ready backpressure. The last-vertex marker rides with each point.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   bus     slave modport of rot_sin_cos_pipe_if (angle load, point in, result out)
// Parameters:
//   DATA_W           signed width of x, y, ox, oy, rx, ry
//   SINCOS_FRACTION  fraction bits of sin/cos (Q1.SINCOS_FRACTION in 18 bits)
// Configuration macro:
//   ROT_SATURATE_EN  defined: clamp the final result to the DATA_W range;
//                    undefined (default): keep the low DATA_W bits (wrap).

module rot_sin_cos_pipe #(
    parameter int DATA_W          = 18,
    parameter int SINCOS_FRACTION = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    rot_sin_cos_pipe_if.slave     bus
);

    localparam int PW = DATA_W + 18;   // product width
    localparam int SW = DATA_W + 19;   // sum width, cannot overflow
    localparam int FW = DATA_W + 20;   // headroom for rounding and offset add

    // Latched angle
    logic signed [17:0]       r_sin;
    logic signed [17:0]       r_cos;

    // Stage 1: products
    logic                     r_v1;
    logic signed [PW-1:0]     r_xcos;
    logic signed [PW-1:0]     r_ysin;
    logic signed [PW-1:0]     r_xsin;
    logic signed [PW-1:0]     r_ycos;
    logic signed [DATA_W-1:0] r_ox1;
    logic signed [DATA_W-1:0] r_oy1;
    logic                     r_last1;

    // Stage 2: rotated sums
    logic                     r_v2;
    logic signed [SW-1:0]     r_rxt;
    logic signed [SW-1:0]     r_ryt;
    logic signed [DATA_W-1:0] r_ox2;
    logic signed [DATA_W-1:0] r_oy2;
    logic                     r_last2;

    // Stage 3: rounded, translated, narrowed result
    logic                     r_v3;
    logic signed [DATA_W-1:0] r_rx;
    logic signed [DATA_W-1:0] r_ry;
    logic                     r_last3;

    logic                     w_advance;
    logic signed [PW-1:0]     w_xcos;
    logic signed [PW-1:0]     w_ysin;
    logic signed [PW-1:0]     w_xsin;
    logic signed [PW-1:0]     w_ycos;
    logic signed [FW-1:0]     w_rnd_x;
    logic signed [FW-1:0]     w_rnd_y;
    logic signed [FW-1:0]     w_rx_full;
    logic signed [FW-1:0]     w_ry_full;

`ifdef ROT_SATURATE_EN
    localparam logic signed [FW-1:0] MAX_V = {{(FW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [FW-1:0] MIN_V = {{(FW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [FW-1:0] v);
        logic signed [FW-1:0] c;
        c = v;
        if (v > MAX_V) begin
            c = MAX_V;
        end else if (v < MIN_V) begin
            c = MIN_V;
        end
        return c[DATA_W-1:0];
    endfunction
`else
    // Screen-wrap arithmetic: discard everything above DATA_W.
    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [FW-1:0] v);
        return v[DATA_W-1:0];
    endfunction
`endif

    // The whole pipe moves together; a full output register blocks everything.
    assign w_advance    = !r_v3 || bus.out_ready;
    assign bus.in_ready = w_advance;

    assign w_xcos = PW'(bus.x) * PW'(r_cos);
    assign w_ysin = PW'(bus.y) * PW'(r_sin);
    assign w_xsin = PW'(bus.x) * PW'(r_sin);
    assign w_ycos = PW'(bus.y) * PW'(r_cos);

    // Half-up rounding: add the first discarded fraction bit after the
    // arithmetic shift (floor), all at full width before narrowing.
    assign w_rnd_x   = {{(FW-1){1'b0}}, r_rxt[SINCOS_FRACTION-1]};
    assign w_rnd_y   = {{(FW-1){1'b0}}, r_ryt[SINCOS_FRACTION-1]};
    assign w_rx_full = FW'(r_rxt >>> SINCOS_FRACTION) + w_rnd_x + FW'(r_ox2);
    assign w_ry_full = FW'(r_ryt >>> SINCOS_FRACTION) + w_rnd_y + FW'(r_oy2);

    // Angle capture is independent of the handshake; a point accepted in the
    // same cycle as ang_load still sees the previous angle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sin <= '0;
            r_cos <= '0;
        end else if (bus.ang_load) begin
            r_sin <= bus.sin_in;
            r_cos <= bus.cos_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_xcos  <= '0;
            r_ysin  <= '0;
            r_xsin  <= '0;
            r_ycos  <= '0;
            r_ox1   <= '0;
            r_oy1   <= '0;
            r_last1 <= 1'b0;
            r_rxt   <= '0;
            r_ryt   <= '0;
            r_ox2   <= '0;
            r_oy2   <= '0;
            r_last2 <= 1'b0;
            r_rx    <= '0;
            r_ry    <= '0;
            r_last3 <= 1'b0;
        end else if (w_advance) begin
            // Stage 1 (valid follows in_valid so bubbles propagate)
            r_v1    <= bus.in_valid;
            r_xcos  <= w_xcos;
            r_ysin  <= w_ysin;
            r_xsin  <= w_xsin;
            r_ycos  <= w_ycos;
            r_ox1   <= bus.ox;
            r_oy1   <= bus.oy;
            r_last1 <= bus.in_last;
            // Stage 2
            r_v2    <= r_v1;
            r_rxt   <= SW'(r_xcos) - SW'(r_ysin);
            r_ryt   <= SW'(r_xsin) + SW'(r_ycos);
            r_ox2   <= r_ox1;
            r_oy2   <= r_oy1;
            r_last2 <= r_last1;
            // Stage 3
            r_v3    <= r_v2;
            r_rx    <= narrow(w_rx_full);
            r_ry    <= narrow(w_ry_full);
            r_last3 <= r_last2;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.rx        = r_rx;
    assign bus.ry        = r_ry;
    assign bus.out_last  = r_last3;

endmodule

// File: tb/tb_rot_sin_cos_pipe.sv
// tb/tb_rot_sin_cos_pipe.sv - self-checking bench for rot_sin_cos_pipe

module tb_rot_sin_cos_pipe;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    rot_sin_cos_pipe_if #(.DATA_W(18)) m ();
    rot_sin_cos_pipe_if #(.DATA_W(10)) s ();

    rot_sin_cos_pipe #(.DATA_W(18), .SINCOS_FRACTION(17)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    rot_sin_cos_pipe #(.DATA_W(10), .SINCOS_FRACTION(17)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s)
    );

    typedef struct {
        logic signed [17:0] x;
        logic signed [17:0] y;
        logic signed [17:0] ox;
        logic signed [17:0] oy;
        bit                 last;
        logic signed [17:0] erx;
        logic signed [17:0] ery;
    } vec_t;

    typedef struct {
        logic signed [17:0] rx;
        logic signed [17:0] ry;
        bit                 last;
        int                 acc;
        bit                 lat;
    } exp_t;

    vec_t tbl [8];
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every accepted result is compared in order.
    always @(negedge clk) begin
        if (!reset && m.out_valid === 1'b1 && m.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx", m.rx, e.rx);
                chk("ry", m.ry, e.ry);
                chk("out_last", m.out_last, e.last);
                if (e.lat) chk("latency", cyc - e.acc, 3);
            end
        end
    end

    task automatic send(input logic signed [17:0] x, input logic signed [17:0] y,
                        input logic signed [17:0] ox, input logic signed [17:0] oy,
                        input bit last, input logic signed [17:0] erx,
                        input logic signed [17:0] ery, input bit lat, input bit ld,
                        input logic signed [17:0] sn, input logic signed [17:0] cs);
        bit ok;
        exp_t e;
        m.x        = x;
        m.y        = y;
        m.ox       = ox;
        m.oy       = oy;
        m.in_last  = last;
        m.in_valid = 1'b1;
        m.ang_load = ld;
        m.sin_in   = sn;
        m.cos_in   = cs;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m.in_ready === 1'b1) begin
                e.rx = erx; e.ry = ery; e.last = last; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            m.ang_load = 1'b0;
            if (ok) break;
        end
        m.in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic ang(input logic signed [17:0] sn, input logic signed [17:0] cs);
        m.ang_load = 1'b1;
        m.sin_in   = sn;
        m.cos_in   = cs;
        @(posedge clk);
        #1;
        m.ang_load = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        errors = 0;
        checks = 0;
        cyc    = 0;

        // 90-degree rotation (sin=131071, cos=0): rx = -y + ox, ry = x + oy for small values
        tbl[0] = '{18'sd100,  18'sd0,    18'sd10,  18'sd20,   1'b0, 18'sd10,    18'sd120};
        tbl[1] = '{-18'sd3,   18'sd4,    18'sd0,   18'sd0,    1'b0, -18'sd4,    -18'sd3};
        tbl[2] = '{18'sd0,    -18'sd200, 18'sd1,   18'sd1,    1'b0, 18'sd201,   18'sd1};
        tbl[3] = '{18'sd1000, 18'sd1000, -18'sd5,  18'sd5,    1'b1, -18'sd1005, 18'sd1005};
`ifdef ROT_SATURATE_EN
        tbl[4] = '{18'sd131071, 18'sd0,  18'sd0,   18'sd10,   1'b0, 18'sd0,     18'sd131071};
`else
        tbl[4] = '{18'sd131071, 18'sd0,  18'sd0,   18'sd10,   1'b0, 18'sd0,     -18'sd131064};
`endif
        tbl[5] = '{18'sd7,    -18'sd7,   -18'sd100, -18'sd100, 1'b0, -18'sd93,  -18'sd93};
        tbl[6] = '{-18'sd1,   18'sd1,    18'sd0,   18'sd0,    1'b0, -18'sd1,    -18'sd1};
        tbl[7] = '{18'sd50,   -18'sd60,  18'sd2,   -18'sd3,   1'b1, 18'sd62,    18'sd47};

        reset = 1'b1;
        m.ang_load = 0; m.sin_in = 0; m.cos_in = 0; m.in_valid = 0;
        m.x = 0; m.y = 0; m.ox = 0; m.oy = 0; m.in_last = 0; m.out_ready = 1'b1;
        s.ang_load = 0; s.sin_in = 0; s.cos_in = 0; s.in_valid = 0;
        s.x = 0; s.y = 0; s.ox = 0; s.oy = 0; s.in_last = 0; s.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", m.out_valid, 0);
        chk("reset_in_ready", m.in_ready, 1);
        chk("reset_rx", m.rx, 0);
        chk("reset_ry", m.ry, 0);
        chk("reset_small_out_valid", s.out_valid, 0);
        @(posedge clk);
        #1;

        // DATA_W=10 boundary: 511*0.7071*2 = 722.66 rounds to 723, wraps to -301
        s.ang_load = 1'b1; s.sin_in = 18'sd92682; s.cos_in = 18'sd92682;
        @(posedge clk);
        #1;
        s.ang_load = 1'b0;
        s.in_valid = 1'b1; s.x = 10'sd511; s.y = -10'sd511; s.ox = 0; s.oy = 0;
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (s.out_valid === 1'b1) seen = 1'b1;
        end
        chk("small_out_valid", seen, 1);
`ifdef ROT_SATURATE_EN
        chk("small_rx", s.rx, 511);
`else
        chk("small_rx", s.rx, -301);
`endif
        chk("small_ry", s.ry, 0);
        @(posedge clk);
        #1;

        // No angle loaded: only the offset survives
        send(18'sd5, 18'sd7, 18'sd3, -18'sd2, 1'b0, 18'sd3, -18'sd2, 1'b1, 1'b0, 0, 0);
        wait_drain();

        // Near-unity cosine: 99.9992 rounds to 100
        ang(18'sd0, 18'sd131071);
        send(18'sd100, -18'sd50, 18'sd0, 18'sd0, 1'b1, 18'sd100, -18'sd50, 1'b1, 1'b0, 0, 0);
        wait_drain();

        // cos=0.5: ties round toward +inf
        ang(18'sd0, 18'sd65536);
        send(18'sd1,  18'sd0, 18'sd0, 18'sd0, 1'b0, 18'sd1,  18'sd0, 1'b1, 1'b0, 0, 0);
        send(-18'sd1, 18'sd0, 18'sd0, 18'sd0, 1'b0, 18'sd0,  18'sd0, 1'b1, 1'b0, 0, 0);
        send(18'sd3,  18'sd0, 18'sd0, 18'sd0, 1'b0, 18'sd2,  18'sd0, 1'b1, 1'b0, 0, 0);
        send(-18'sd3, 18'sd0, 18'sd0, 18'sd0, 1'b1, -18'sd1, 18'sd0, 1'b1, 1'b0, 0, 0);
        wait_drain();

        // Table stream, back to back at 90 degrees
        ang(18'sd131071, 18'sd0);
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].ox, tbl[i].oy, tbl[i].last,
                 tbl[i].erx, tbl[i].ery, 1'b1, 1'b0, 0, 0);
        end
        wait_drain();

        // Backpressure with a full pipe
        m.out_ready = 1'b0;
        send(18'sd1, 18'sd2, 18'sd0, 18'sd0, 1'b0, -18'sd2, 18'sd1, 1'b0, 1'b0, 0, 0);
        send(18'sd3, 18'sd4, 18'sd0, 18'sd0, 1'b1, -18'sd4, 18'sd3, 1'b0, 1'b0, 0, 0);
        send(18'sd5, 18'sd6, 18'sd0, 18'sd0, 1'b0, -18'sd6, 18'sd5, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", m.in_ready, 0);
            chk("stall_out_valid", m.out_valid, 1);
            chk("stall_rx", m.rx, -2);
            chk("stall_ry", m.ry, 1);
            chk("stall_out_last", m.out_last, 0);
        end
        @(posedge clk);
        #1;
        m.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_out_valid", m.out_valid, 1);
        end
        @(negedge clk);
        chk("drain_done", m.out_valid, 0);
        chk("drain_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // ang_load with point A: A uses old (90 deg), B uses new (identity)
        send(18'sd10, 18'sd20, 18'sd0, 18'sd0, 1'b0, -18'sd20, 18'sd10, 1'b1, 1'b1, 18'sd0, 18'sd131071);
        send(18'sd10, 18'sd20, 18'sd0, 18'sd0, 1'b1, 18'sd10,  18'sd20, 1'b1, 1'b0, 0, 0);
        wait_drain();

        // Reset mid-stream: in-flight points vanish, angle returns to zero
        send(18'sd1, 18'sd1, 18'sd0, 18'sd0, 1'b0, 18'sd1, 18'sd1, 1'b0, 1'b0, 0, 0);
        send(18'sd2, 18'sd2, 18'sd0, 18'sd0, 1'b0, 18'sd2, 18'sd2, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", m.out_valid, 0);
        chk("rst_mid_in_ready", m.in_ready, 1);
        chk("rst_mid_rx", m.rx, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_output", m.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(18'sd5, 18'sd7, 18'sd3, -18'sd2, 1'b1, 18'sd3, -18'sd2, 1'b1, 1'b0, 0, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
